// File: rtl/ram64_arbiter_if.sv
// ram64_arbiter_if: requester-side bundle for the two-port ram64 arbiter.
//   Per port p in {0,1}:
//     req<p>     requester -> arbiter  request, held with a stable command until gnt<p>
//     we<p>      requester -> arbiter  1 = write, 0 = read
//     addr<p>    requester -> arbiter  word address
//     wdata<p>   requester -> arbiter  write data
//     gnt<p>     arbiter -> requester  high for the single ACCESS cycle of this port
//     rvalid<p>  arbiter -> requester  one-cycle read data valid pulse
//     rdata<p>   arbiter -> requester  read data, held until the next read on this port
//   Modports: master (requester side), slave (arbiter side).
interface ram64_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  gnt0, rvalid0, rdata0,
        input  gnt1, rvalid1, rdata1
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output gnt0, rvalid0, rdata0,
        output gnt1, rvalid1, rdata1
    );
endinterface

// File: rtl/ram64_arbiter.sv
// ram64_arbiter: round-robin access controller sharing one 64x16 ram64 (u_ram)
// between two requesters. One access per two cycles (IDLE -> ACCESS -> IDLE).
//   clk        system clock
//   reset      synchronous active-high reset (RAM contents are not cleared)
//   bus        ram64_arbiter_if.slave: req/we/addr/wdata in, gnt/rvalid/rdata out, per port
//   busy       high while the FSM is in ACCESS
// Optional feature macro RAM64_ARB_STATS_EN adds:
//   stats_clr  synchronous clear of both grant counters (wins over increment)
//   gcnt0/1    saturating per-port grant counters, CNT_W bits

// 64x16 RAM with asynchronous read: the arbiter samples 'out' at the edge
// that closes the ACCESS cycle, so the data must be valid within that cycle.
module ram64 (
    input  logic        clk,
    input  logic [15:0] in,
    input  logic        load,
    input  logic [5:0]  address,
    output logic [15:0] out
);
    logic [15:0] mem [64];

    always_ff @(posedge clk) begin
        if (load) begin
            mem[address] <= in;
        end
    end

    assign out = mem[address];
endmodule

module ram64_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    ram64_arbiter_if.slave    bus,
`ifdef RAM64_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [CNT_W-1:0]  gcnt0,
    output logic [CNT_W-1:0]  gcnt1,
`endif
    output logic              busy
);
    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic              last_port_reg;
    logic              id_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              grant_valid;
    logic              sel_port;

    // Per-port views of the interface so the port logic can be generated.
    logic [1:0]        req_w;
    logic              we_w    [2];
    logic [ADDR_W-1:0] addr_w  [2];
    logic [DATA_W-1:0] wdata_w [2];
    logic [1:0]        gnt_w;
    logic [1:0]        rvalid_reg;
    logic [DATA_W-1:0] rdata_reg [2];

    logic [DATA_W-1:0] ram_out;
    logic              ram_load;

    assign req_w      = {bus.req1, bus.req0};
    assign we_w[0]    = bus.we0;
    assign we_w[1]    = bus.we1;
    assign addr_w[0]  = bus.addr0;
    assign addr_w[1]  = bus.addr1;
    assign wdata_w[0] = bus.wdata0;
    assign wdata_w[1] = bus.wdata1;

    assign bus.gnt0    = gnt_w[0];
    assign bus.gnt1    = gnt_w[1];
    assign bus.rvalid0 = rvalid_reg[0];
    assign bus.rvalid1 = rvalid_reg[1];
    assign bus.rdata0  = rdata_reg[0];
    assign bus.rdata1  = rdata_reg[1];

    assign busy = (state_reg == ACCESS);

    // Reset in the ACCESS cycle must not leave a half-done write behind.
    assign ram_load = busy & we_reg & ~reset;

    ram64 u_ram (
        .clk     (clk),
        .in      (wdata_reg),
        .load    (ram_load),
        .address (addr_reg),
        .out     (ram_out)
    );

    always_comb begin
        state_next  = state_reg;
        grant_valid = 1'b0;
        sel_port    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_w != 2'b00) begin
                    grant_valid = 1'b1;
                    state_next  = ACCESS;
                    // On a tie the port that did not go last wins.
                    sel_port    = (req_w == 2'b11) ? ~last_port_reg : req_w[1];
                end
            end
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            last_port_reg <= 1'b1;
            id_reg        <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_valid) begin
                id_reg    <= sel_port;
                we_reg    <= we_w[sel_port];
                addr_reg  <= addr_w[sel_port];
                wdata_reg <= wdata_w[sel_port];
            end
            if (busy) begin
                last_port_reg <= id_reg;
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic port_access;
        assign port_access = busy & (id_reg == gi[0]);
        assign gnt_w[gi]   = port_access;

        always_ff @(posedge clk) begin
            if (reset) begin
                rvalid_reg[gi] <= 1'b0;
                rdata_reg[gi]  <= '0;
            end else begin
                rvalid_reg[gi] <= port_access & ~we_reg;
                if (port_access & ~we_reg) begin
                    rdata_reg[gi] <= ram_out;
                end
            end
        end
    end

`ifdef RAM64_ARB_STATS_EN
    logic [CNT_W-1:0] gcnt_reg [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_stats
        always_ff @(posedge clk) begin
            if (reset || stats_clr) begin
                gcnt_reg[gi] <= '0;
            end else if (gnt_w[gi] && (gcnt_reg[gi] != {CNT_W{1'b1}})) begin
                gcnt_reg[gi] <= gcnt_reg[gi] + 1'b1;
            end
        end
    end

    assign gcnt0 = gcnt_reg[0];
    assign gcnt1 = gcnt_reg[1];
`endif
endmodule
